// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for the iterative SubBytes stage: a 128-bit state in with
// valid/ready, the substituted state out with valid/ready, plus a busy flag.
interface sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Upstream/downstream side that drives states in and consumes results
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // The SubBytes block itself
    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes over a full 128-bit state. LANES combinational S-boxes
// substitute LANES bytes per cycle in place in a working register; the finished
// state is registered into out_state and held until downstream accepts it.

// One combinational AES S-box: multiplicative inverse in GF(2^8) computed as
// x^254 (which also maps 0 to 0), followed by the AES affine transform.
module sub_byte_combinational (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128, then affine map with constant 0x63
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            reset,
    sub_bytes_iter_if.slave bus
);
    localparam int GROUPS = 16 / LANES;
    // Keep at least one bit so the LANES=16 build (single group) still has a counter
    localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [127:0]  work_reg, work_next;
    logic [127:0]  out_state_reg, out_state_next;
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    // Lane gi always handles byte LANES*count + gi of the working state
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi] = work_reg[7'(8 * (LANES * int'(count_reg) + gi)) +: 8];
            sub_byte_combinational u_sbox (
                .din  (lane_in[gi]),
                .dout (lane_out[gi])
            );
        end
    endgenerate

    // State, counter and data registers; reset discards any work in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            work_reg      <= '0;
            out_state_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            work_reg      <= work_next;
            out_state_reg <= out_state_next;
        end
    end

    // Next-state logic: load in IDLE, substitute one group per RUN cycle, hold in DONE
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        work_next      = work_reg;
        out_state_next = out_state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    work_next  = bus.in_state;
                    count_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    work_next[7'(8 * (LANES * int'(count_reg) + i)) +: 8] = lane_out[i];
                end
                if (count_reg == LAST) begin
                    // Final group goes straight into the output register
                    out_state_next = work_next;
                    state_next     = DONE;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from registered state only
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_state = out_state_reg;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: LANES=4 gets the full handshake,
// backpressure, reset and back-to-back scoreboard tests; LANES=1 and 16 get
// latency and data checks. Reference S-box is built from brute-force inverses.
module tb_sub_bytes_iter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sub_bytes_iter_if bus4 ();
    sub_bytes_iter_if bus1 ();
    sub_bytes_iter_if bus16 ();

    sub_bytes_iter #(.LANES(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
    sub_bytes_iter #(.LANES(1))  u_dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    sub_bytes_iter #(.LANES(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    int           checks   = 0;
    int           failures = 0;
    int           popped   = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_q [$];

    localparam logic [127:0] IN2  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] EXP2 = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] ALL63 = {16{8'h63}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Carry-less multiply then reduce by 0x11b
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] tb_affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_tab[s[8*k +: 8]];
        return r;
    endfunction

    // Scoreboard for the LANES=4 instance, sampled mid-cycle
    always @(negedge clk) begin
        logic [127:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus4.in_valid && bus4.in_ready) exp_q.push_back(model(bus4.in_state));
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", bus4.out_state, e);
                    popped++;
                    $display("txn %0d out=%h exp=%h", popped, bus4.out_state, e);
                end
            end
        end
    end

    task automatic set_in(input int sel, input logic v, input logic [127:0] st);
        case (sel)
            1:  begin bus1.in_valid  = v; bus1.in_state  = st; end
            16: begin bus16.in_valid = v; bus16.in_state = st; end
            default: begin bus4.in_valid = v; bus4.in_state = st; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic r);
        case (sel)
            1:  bus1.out_ready  = r;
            16: bus16.out_ready = r;
            default: bus4.out_ready = r;
        endcase
    endtask

    function automatic logic get_in_ready(input int sel);
        case (sel)
            1:  return bus1.in_ready;
            16: return bus16.in_ready;
            default: return bus4.in_ready;
        endcase
    endfunction

    function automatic logic get_out_valid(input int sel);
        case (sel)
            1:  return bus1.out_valid;
            16: return bus16.out_valid;
            default: return bus4.out_valid;
        endcase
    endfunction

    function automatic logic [127:0] get_out_state(input int sel);
        case (sel)
            1:  return bus1.out_state;
            16: return bus16.out_state;
            default: return bus4.out_state;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int sel, input logic [127:0] st, input logic hold);
        int n;
        n = 0;
        set_in(sel, 1'b1, st);
        forever begin
            @(negedge clk);
            if (get_in_ready(sel)) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 128'(n), 128'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) set_in(sel, 1'b0, st);
    endtask

    task automatic wait_out(input int sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!get_out_valid(sel) && lat < 100);
        if (!get_out_valid(sel)) check("out_timeout", 128'(lat), 128'd0);
    endtask

    task automatic run_basic(input int sel, input logic [127:0] st, input logic [127:0] exp,
                             input int exp_lat, input string tag);
        int lat;
        send(sel, st, 1'b0);
        wait_out(sel, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, get_out_state(sel), exp);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(sel, 1'b0);
        check({tag, "_out_valid_drop"}, 128'(get_out_valid(sel)), 128'd0);
        check({tag, "_in_ready"}, 128'(get_in_ready(sel)), 128'd1);
    endtask

    initial begin
        logic [7:0]   inv;
        logic [127:0] st;
        int           lat;
        int           base;
        int           n;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = tb_affine(inv);
        end

        reset = 1'b1;
        set_in(4, 1'b0, '0); set_in(1, 1'b0, '0); set_in(16, 1'b0, '0);
        set_ordy(4, 1'b0); set_ordy(1, 1'b0); set_ordy(16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus4.out_valid), 128'd0);
        check("rst_out_state", bus4.out_state, 128'd0);
        check("rst_busy", 128'(bus4.busy), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(bus4.in_ready), 128'd1);
        @(posedge clk);
        #1;

        // Zero state and the 00..0f byte ramp
        run_basic(4, 128'd0, ALL63, 4, "t1");
        run_basic(4, IN2, EXP2, 4, "t2");

        // Backpressure: result must be held for 10 cycles
        st = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(4, st, 1'b0);
        wait_out(4, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 128'(bus4.out_valid), 128'd1);
            check("bp_out_state", bus4.out_state, model(st));
            check("bp_in_ready", 128'(bus4.in_ready), 128'd0);
        end
        set_ordy(4, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(4, 1'b0);
        check("bp_release_valid", 128'(bus4.out_valid), 128'd0);
        check("bp_release_in_ready", 128'(bus4.in_ready), 128'd1);

        // Reset while RUN has reached count=2
        send(4, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst2_out_valid", 128'(bus4.out_valid), 128'd0);
        check("rst2_out_state", bus4.out_state, 128'd0);
        check("rst2_busy", 128'(bus4.busy), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", 128'(bus4.in_ready), 128'd1);
        @(posedge clk);
        #1;
        run_basic(4, 128'h53, {{15{8'h63}}, 8'hed}, 4, "t4");

        // Back-to-back with in_valid held and out_ready high
        base = popped;
        set_ordy(4, 1'b1);
        for (int i = 0; i < 8; i++) send(4, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
        set_in(4, 1'b0, '0);
        n = 0;
        while ((popped - base < 8 || bus4.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        set_ordy(4, 1'b0);
        check("b2b_count", 128'(popped - base), 128'd8);
        check("b2b_queue_left", 128'(exp_q.size()), 128'd0);

        // Other lane counts
        run_basic(1, 128'd0, ALL63, 16, "l1_t1");
        run_basic(1, IN2, EXP2, 16, "l1_t2");
        run_basic(16, 128'd0, ALL63, 1, "l16_t1");
        run_basic(16, IN2, EXP2, 1, "l16_t2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
